// File: rtl/pattern_fill_pkg.sv
// rtl/pattern_fill_pkg.sv - shared types, sel encodings and replication helper for the fill engine
package pattern_fill_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [1:0] SEL_1B = 2'd0;
    localparam logic [1:0] SEL_2B = 2'd1;
    localparam logic [1:0] SEL_4B = 2'd2;
    localparam logic [1:0] SEL_8B = 2'd3;

    // Widest word the helper produces; callers keep the low OUT_W bits.
    localparam int REP_MAX_W = 256;

    function automatic logic [REP_MAX_W-1:0] rep_word(input logic [7:0] pat,
                                                      input logic [1:0] sel);
        logic [REP_MAX_W-1:0] w;
        case (sel)
            SEL_1B:  w = {REP_MAX_W{pat[0]}};
            SEL_2B:  w = {(REP_MAX_W/2){pat[1:0]}};
            SEL_4B:  w = {(REP_MAX_W/4){pat[3:0]}};
            default: w = {(REP_MAX_W/8){pat[7:0]}};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/pattern_rep.sv
// rtl/pattern_rep.sv - combinational replicator of a 1/2/4/8-bit pattern across an OUT_W-bit word
module pattern_rep
    import pattern_fill_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  logic [7:0]       pat_i,
    input  logic [1:0]       sel_i,
    output logic [OUT_W-1:0] word_o
);

    logic [OUT_W-1:0] rep1_w;
    logic [OUT_W-1:0] rep2_w;
    logic [OUT_W-1:0] rep4_w;
    logic [OUT_W-1:0] rep8_w;

    assign rep1_w = {OUT_W{pat_i[0]}};
    assign rep2_w = {(OUT_W/2){pat_i[1:0]}};
    assign rep4_w = {(OUT_W/4){pat_i[3:0]}};
    assign rep8_w = {(OUT_W/8){pat_i[7:0]}};

    always_comb begin
        word_o = rep8_w;
        case (sel_i)
            SEL_1B:  word_o = rep1_w;
            SEL_2B:  word_o = rep2_w;
            SEL_4B:  word_o = rep4_w;
            default: word_o = rep8_w;
        endcase
    end

endmodule

// File: rtl/pattern_fill_ctrl.sv
// rtl/pattern_fill_ctrl.sv - command-driven engine streaming a programmed number of replicated pattern words
module pattern_fill_ctrl
    import pattern_fill_pkg::*;
#(
    parameter int OUT_W  = 32,
    parameter int BEAT_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_pat,
    input  logic [1:0]        cmd_sel,
    input  logic [BEAT_W-1:0] cmd_beats,
    input  logic              cmd_alt,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [BEAT_W-1:0] ONE_BEAT = BEAT_W'(1);

    state_e            state_q, state_d;
    logic [7:0]        pat_q, pat_d;
    logic [1:0]        sel_q, sel_d;
    logic              alt_q, alt_d;
    logic [BEAT_W-1:0] remaining_q, remaining_d;
    logic              alt_phase_q, alt_phase_d;
    logic              last_q, last_d;
    logic              done_q, done_d;

    logic [OUT_W-1:0]  rep_w;
    logic              accept_w;
    logic              handshake_w;

    pattern_rep #(.OUT_W(OUT_W)) u_rep (
        .pat_i  (pat_q),
        .sel_i  (sel_q),
        .word_o (rep_w)
    );

    assign cmd_ready   = (state_q == IDLE) && !abort;
    assign accept_w    = cmd_valid && cmd_ready;
    assign out_valid   = (state_q == RUN);
    assign busy        = (state_q == RUN);
    assign handshake_w = out_valid && out_ready;
    assign out_last    = last_q;
    assign done        = done_q;

    // The word is derived from the latched command, so it is inherently stable under back-pressure.
    assign out_data = out_valid ? (rep_w ^ {OUT_W{alt_q & alt_phase_q}}) : '0;

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        sel_d       = sel_q;
        alt_d       = alt_q;
        remaining_d = remaining_q;
        alt_phase_d = alt_phase_q;
        last_d      = last_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_w) begin
                    pat_d = cmd_pat;
                    sel_d = cmd_sel;
                    alt_d = cmd_alt;
                    if (cmd_beats == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = RUN;
                        remaining_d = cmd_beats;
                        last_d      = (cmd_beats == ONE_BEAT);
                        alt_phase_d = 1'b0;
                    end
                end
            end
            RUN: begin
                // Abort wins over a coinciding handshake: the word counts as sent but nothing follows.
                if (abort) begin
                    state_d     = IDLE;
                    remaining_d = '0;
                    last_d      = 1'b0;
                    alt_phase_d = 1'b0;
                end else if (handshake_w) begin
                    if (remaining_q == ONE_BEAT) begin
                        state_d     = IDLE;
                        remaining_d = '0;
                        last_d      = 1'b0;
                        alt_phase_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        remaining_d = remaining_q - ONE_BEAT;
                        alt_phase_d = !alt_phase_q;
                        last_d      = (remaining_d == ONE_BEAT);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            sel_q       <= '0;
            alt_q       <= 1'b0;
            remaining_q <= '0;
            alt_phase_q <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            sel_q       <= sel_d;
            alt_q       <= alt_d;
            remaining_q <= remaining_d;
            alt_phase_q <= alt_phase_d;
            last_q      <= last_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_pattern_fill_ctrl.sv
// tb/tb_pattern_fill_ctrl.sv - self-checking bench for pattern_fill_ctrl against a queue-based model
module tb_pattern_fill_ctrl;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_pat;
    logic [1:0]  cmd_sel;
    logic [7:0]  cmd_beats;
    logic        cmd_alt;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    pattern_fill_ctrl #(.OUT_W(32), .BEAT_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_pat   (cmd_pat),
        .cmd_sel   (cmd_sel),
        .cmd_beats (cmd_beats),
        .cmd_alt   (cmd_alt),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_done  = 0;
    int ready_mode = 0;
    int ready_idx  = 0;
    bit abort_rand = 0;
    bit model_done = 0;
    bit nd;
    logic [31:0] exp_q[$];
    logic [32:0] got_q[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] model_rep(input logic [7:0] p, input logic [1:0] s);
        logic [31:0] r;
        int k;
        k = 1 << s;
        for (int i = 0; i < 32; i++) r[i] = p[i % k];
        return r;
    endfunction

    // Reference: one queue entry per word still owed to the consumer.
    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                exp_q.delete();
                model_done = 0;
            end else begin
                nd = 0;
                if (exp_q.size() > 0) begin
                    if (abort) exp_q.delete();
                    else if (out_ready) begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) nd = 1;
                    end
                end else if (cmd_valid && !abort) begin
                    if (cmd_beats == 0) nd = 1;
                    else for (int b = 0; b < int'(cmd_beats); b++)
                        exp_q.push_back(model_rep(cmd_pat, cmd_sel) ^ ((cmd_alt && (b % 2 == 1)) ? 32'hFFFF_FFFF : 32'h0));
                end
                model_done = nd;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                chk("cmd_ready", 64'(cmd_ready), 64'(exp_q.size() == 0 && !abort));
                chk("busy", 64'(busy), 64'(exp_q.size() > 0));
                chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
                chk("out_last", 64'(out_last), 64'(exp_q.size() == 1));
                chk("done", 64'(done), 64'(model_done));
                if (exp_q.size() > 0 && out_valid) chk("out_data", 64'(out_data), 64'(exp_q[0]));
                if (out_valid && out_ready) got_q.push_back({out_last, out_data});
                if (done) n_done++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (ready_mode == 0) out_ready = 1'b1;
            else if (ready_mode == 1) out_ready = 1'($urandom % 2);
            else begin
                out_ready = (ready_idx % 4 == 0) || (ready_idx % 4 == 3);
                ready_idx++;
            end
            if (abort_rand) abort = ($urandom % 16 == 0);
        end
    end

    task automatic send_cmd(input logic [7:0] p, input logic [1:0] s, input logic [7:0] b, input logic a);
        int n;
        cmd_pat = p; cmd_sel = s; cmd_beats = b; cmd_alt = a; cmd_valid = 1'b1;
        #1;
        n = 0;
        while (!cmd_ready && n < 300) begin
            @(posedge clock); #2; n++;
        end
        if (n == 300) chk("cmd_accept_timeout", 64'd0, 64'd1);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(posedge clock); #1; n++;
        end
        if (n == 400) chk("idle_timeout", 64'd0, 64'd1);
        repeat (3) begin @(posedge clock); #1; end
    endtask

    task automatic clear_logs();
        got_q.delete();
        n_done = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_pat = '0; cmd_sel = '0; cmd_beats = '0;
        cmd_alt = 1'b0; abort = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        #11 reset = 1'b0;
        @(posedge clock); #1;

        clear_logs();
        send_cmd(8'h01, 2'd0, 8'd1, 1'b0);
        wait_idle();
        chk("t1_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() >= 1) chk("t1_word", 64'(got_q[0]), 64'h1_FFFF_FFFF);
        chk("t1_done", 64'(n_done), 64'd1);

        clear_logs();
        send_cmd(8'h01, 2'd1, 8'd1, 1'b0);
        send_cmd(8'h03, 2'd2, 8'd1, 1'b0);
        send_cmd(8'hA5, 2'd3, 8'd1, 1'b0);
        send_cmd(8'hF3, 2'd2, 8'd1, 1'b0);
        wait_idle();
        chk("t2_count", 64'(got_q.size()), 64'd4);
        if (got_q.size() >= 4) begin
            chk("t2_sel1", 64'(got_q[0][31:0]), 64'h5555_5555);
            chk("t2_sel2", 64'(got_q[1][31:0]), 64'h3333_3333);
            chk("t2_sel3", 64'(got_q[2][31:0]), 64'hA5A5_A5A5);
            chk("t2_upper_ignored", 64'(got_q[3][31:0]), 64'h3333_3333);
        end

        clear_logs();
        send_cmd(8'h01, 2'd3, 8'd3, 1'b1);
        wait_idle();
        chk("t3_count", 64'(got_q.size()), 64'd3);
        if (got_q.size() >= 3) begin
            chk("t3_beat1", 64'(got_q[0]), 64'h0_0101_0101);
            chk("t3_beat2", 64'(got_q[1]), 64'h0_FEFE_FEFE);
            chk("t3_beat3", 64'(got_q[2]), 64'h1_0101_0101);
        end

        clear_logs();
        ready_idx = 0; ready_mode = 2;
        send_cmd(8'h3C, 2'd3, 8'd4, 1'b1);
        wait_idle();
        ready_mode = 0;
        chk("t4_count", 64'(got_q.size()), 64'd4);
        chk("t4_done", 64'(n_done), 64'd1);
        if (got_q.size() >= 4) begin
            chk("t4_beat2", 64'(got_q[1][31:0]), 64'hC3C3_C3C3);
            chk("t4_beat4", 64'(got_q[3]), 64'h1_C3C3_C3C3);
        end

        clear_logs();
        send_cmd(8'hFF, 2'd3, 8'd0, 1'b0);
        wait_idle();
        chk("t5_zero_count", 64'(got_q.size()), 64'd0);
        chk("t5_zero_done", 64'(n_done), 64'd1);

        clear_logs();
        send_cmd(8'h0F, 2'd3, 8'd5, 1'b0);
        @(posedge clock); #1;
        abort = 1'b1;
        #1 chk("t5_abort_blocks_ready", 64'(cmd_ready), 64'd0);
        @(posedge clock); #1;
        abort = 1'b0;
        #1;
        chk("t5_abort_valid", 64'(out_valid), 64'd0);
        chk("t5_abort_ready", 64'(cmd_ready), 64'd1);
        wait_idle();
        chk("t5_abort_count", 64'(got_q.size()), 64'd2);
        chk("t5_abort_done", 64'(n_done), 64'd0);

        ready_mode = 1; abort_rand = 1;
        for (int i = 0; i < 40; i++) begin
            send_cmd(8'($urandom), 2'($urandom), 8'($urandom_range(0, 6)), 1'($urandom));
            if ($urandom % 3 == 0) wait_idle();
        end
        abort_rand = 0; abort = 1'b0;
        wait_idle();
        ready_mode = 0;

        clear_logs();
        send_cmd(8'h5A, 2'd3, 8'd5, 1'b0);
        @(posedge clock); #3;
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_data", 64'(out_data), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_last", 64'(out_last), 64'd0);
        chk("t6_rst_done", 64'(done), 64'd0);
        @(posedge clock); #3;
        reset = 1'b0;
        @(posedge clock); #1;
        clear_logs();
        send_cmd(8'h06, 2'd2, 8'd2, 1'b1);
        wait_idle();
        chk("t6_after_count", 64'(got_q.size()), 64'd2);
        if (got_q.size() >= 2) begin
            chk("t6_after_beat1", 64'(got_q[0]), 64'h0_6666_6666);
            chk("t6_after_beat2", 64'(got_q[1]), 64'h1_9999_9999);
        end
        chk("t6_after_done", 64'(n_done), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
